// File: rtl/ssd1306_fb_flush.sv
// ssd1306_fb_flush: streams one SSD1306 frame from framebuffer RAM to the panel
// through the I2C API block, one API function at a time.
// Build option: define SSD1306_INIT_EN to send the panel power-up command list
// once, ahead of the first frame after reset.
module ssd1306_fb_flush #(
  parameter int         WIDTH        = 128,
  parameter int         PAGES        = 8,
  parameter logic [6:0] SLAVE_ADDR   = 7'h3C,
  parameter logic [7:0] FN_IDLE      = 8'hFF,
  // Function codes; override to match the API block's encoding.
  parameter logic [7:0] FN_START     = 8'h01,
  parameter logic [7:0] FN_WRITE_RAW = 8'h02,
  parameter logic [7:0] FN_STOP      = 8'h03
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_req,
  output logic       busy,
  output logic       flush_done,
  output logic       fb_rd,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_rdata,
  output logic       api_enable,
  output logic [7:0] api_function,
  output logic [6:0] api_slave_addr,
  output logic [7:0] api_device_register,
  output logic [7:0] api_data_tx,
  input  logic       api_ready,
  input  logic       api_done
);

  // Top-level sequencer states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_END   = 3'd6;
`ifdef SSD1306_INIT_EN
  localparam logic [2:0] S_INIT  = 3'd7;
  localparam logic [4:0] INIT_LAST = 5'd27;
`endif

  // Per-operation handshake states
  localparam logic [1:0] H_OFF   = 2'd0;
  localparam logic [1:0] H_ISSUE = 2'd1;
  localparam logic [1:0] H_WAIT  = 2'd2;
  localparam logic [1:0] H_GAP   = 2'd3;

  localparam logic [4:0] CMD_LAST = 5'd8;
  localparam logic [4:0] HDR_LAST = 5'd1;
  localparam logic [9:0] LAST_IDX = 10'(WIDTH * PAGES - 1);

  logic [2:0]  top;
  logic [1:0]  hs;
  logic [4:0]  op_idx;
  logic [4:0]  op_inc;
  logic [9:0]  byte_idx;
  logic        pending;
  logic [15:0] op_next;
  logic        list_last;
`ifdef SSD1306_INIT_EN
  logic        init_done;
`endif

  assign api_slave_addr      = SLAVE_ADDR;
  assign api_device_register = 8'h00;
  assign op_inc              = op_idx + 5'd1;

  // Addressing preamble: full column and page window, horizontal mode assumed.
  function automatic logic [15:0] cmd_op(input logic [4:0] idx);
    logic [15:0] op;
    case (idx)
      5'd0:    op = {FN_START, 8'h00};
      5'd1:    op = {FN_WRITE_RAW, 8'h00};
      5'd2:    op = {FN_WRITE_RAW, 8'h21};
      5'd3:    op = {FN_WRITE_RAW, 8'h00};
      5'd4:    op = {FN_WRITE_RAW, 8'(WIDTH - 1)};
      5'd5:    op = {FN_WRITE_RAW, 8'h22};
      5'd6:    op = {FN_WRITE_RAW, 8'h00};
      5'd7:    op = {FN_WRITE_RAW, 8'(PAGES - 1)};
      default: op = {FN_STOP, 8'h00};
    endcase
    return op;
  endfunction

  // Data transfer header: START then the 0x40 data control byte.
  function automatic logic [15:0] hdr_op(input logic [4:0] idx);
    logic [15:0] op;
    if (idx == 5'd0) op = {FN_START, 8'h00};
    else             op = {FN_WRITE_RAW, 8'h40};
    return op;
  endfunction

`ifdef SSD1306_INIT_EN
  // Power-up list: START, control byte 0x00, 25 command bytes, STOP.
  function automatic logic [15:0] init_op(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd2:    b = 8'hAE;
      5'd3:    b = 8'hD5;
      5'd4:    b = 8'h80;
      5'd5:    b = 8'hA8;
      5'd6:    b = 8'(PAGES * 8 - 1);
      5'd7:    b = 8'hD3;
      5'd8:    b = 8'h00;
      5'd9:    b = 8'h40;
      5'd10:   b = 8'h8D;
      5'd11:   b = 8'h14;
      5'd12:   b = 8'h20;
      5'd13:   b = 8'h00;
      5'd14:   b = 8'hA1;
      5'd15:   b = 8'hC8;
      5'd16:   b = 8'hDA;
      5'd17:   b = 8'h12;
      5'd18:   b = 8'h81;
      5'd19:   b = 8'hCF;
      5'd20:   b = 8'hD9;
      5'd21:   b = 8'hF1;
      5'd22:   b = 8'hDB;
      5'd23:   b = 8'h40;
      5'd24:   b = 8'hA4;
      5'd25:   b = 8'hA6;
      5'd26:   b = 8'hAF;
      default: b = 8'h00;
    endcase
    if (idx == 5'd0) return {FN_START, 8'h00};
    if (idx == INIT_LAST) return {FN_STOP, 8'h00};
    return {FN_WRITE_RAW, b};
  endfunction
`endif

  // Look up the operation that follows the current one in the active list;
  // at the end of a list this is the first operation of the next list.
  always_comb begin
    op_next   = {FN_IDLE, 8'h00};
    list_last = 1'b0;
    case (top)
`ifdef SSD1306_INIT_EN
      S_INIT: begin
        list_last = (op_idx == INIT_LAST);
        op_next   = list_last ? cmd_op(5'd0) : init_op(op_inc);
      end
`endif
      S_CMD: begin
        list_last = (op_idx == CMD_LAST);
        op_next   = list_last ? hdr_op(5'd0) : cmd_op(op_inc);
      end
      S_HDR: begin
        list_last = (op_idx == HDR_LAST);
        op_next   = hdr_op(op_inc);
      end
      default: ;
    endcase
  end

  // Frame sequencer and API handshake; all outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top          <= S_IDLE;
      hs           <= H_OFF;
      op_idx       <= 5'd0;
      byte_idx     <= 10'd0;
      pending      <= 1'b0;
`ifdef SSD1306_INIT_EN
      init_done    <= 1'b0;
`endif
      busy         <= 1'b0;
      flush_done   <= 1'b0;
      fb_rd        <= 1'b0;
      fb_addr      <= 10'd0;
      api_function <= FN_IDLE;
      api_data_tx  <= 8'h00;
      api_enable   <= 1'b0;
    end else begin
      api_enable <= 1'b1;
      flush_done <= 1'b0;
      // Requests arriving mid-frame coalesce into a single queued flush.
      if (flush_req && busy) pending <= 1'b1;

      case (top)
        S_IDLE: begin
          if (flush_req || pending) begin
            busy         <= 1'b1;
            pending      <= 1'b0;
            op_idx       <= 5'd0;
            hs           <= H_ISSUE;
            api_function <= FN_START;
            api_data_tx  <= 8'h00;
`ifdef SSD1306_INIT_EN
            top          <= init_done ? S_CMD : S_INIT;
`else
            top          <= S_CMD;
`endif
          end
        end

        S_FETCH: begin
          fb_rd <= 1'b0;
          top   <= S_LATCH;
        end

        // RAM data is valid here, one cycle after the read strobe.
        S_LATCH: begin
          api_data_tx  <= fb_rdata;
          api_function <= FN_WRITE_RAW;
          hs           <= H_ISSUE;
          top          <= S_DATA;
        end

        default: begin
          case (hs)
            H_ISSUE: begin
              if (api_ready) hs <= H_WAIT;
            end

            // The code stays put until the API reports completion.
            H_WAIT: begin
              if (api_done) begin
                hs           <= H_GAP;
                api_function <= FN_IDLE;
                if (top == S_END) flush_done <= 1'b1;
              end
            end

            H_GAP: begin
              if (api_ready) begin
                case (top)
`ifdef SSD1306_INIT_EN
                  S_INIT: begin
                    api_function <= op_next[15:8];
                    api_data_tx  <= op_next[7:0];
                    hs           <= H_ISSUE;
                    if (list_last) begin
                      op_idx    <= 5'd0;
                      init_done <= 1'b1;
                      top       <= S_CMD;
                    end else begin
                      op_idx <= op_inc;
                    end
                  end
`endif
                  S_CMD: begin
                    api_function <= op_next[15:8];
                    api_data_tx  <= op_next[7:0];
                    hs           <= H_ISSUE;
                    if (list_last) begin
                      op_idx <= 5'd0;
                      top    <= S_HDR;
                    end else begin
                      op_idx <= op_inc;
                    end
                  end
                  S_HDR: begin
                    if (list_last) begin
                      hs      <= H_OFF;
                      top     <= S_FETCH;
                      fb_rd   <= 1'b1;
                      fb_addr <= byte_idx;
                    end else begin
                      api_function <= op_next[15:8];
                      api_data_tx  <= op_next[7:0];
                      hs           <= H_ISSUE;
                      op_idx       <= op_inc;
                    end
                  end
                  // The index never advances past the last byte.
                  S_DATA: begin
                    if (byte_idx == LAST_IDX) begin
                      top          <= S_END;
                      api_function <= FN_STOP;
                      api_data_tx  <= 8'h00;
                      hs           <= H_ISSUE;
                    end else begin
                      byte_idx <= byte_idx + 10'd1;
                      fb_addr  <= byte_idx + 10'd1;
                      fb_rd    <= 1'b1;
                      hs       <= H_OFF;
                      top      <= S_FETCH;
                    end
                  end
                  S_END: begin
                    top      <= S_IDLE;
                    busy     <= 1'b0;
                    hs       <= H_OFF;
                    byte_idx <= 10'd0;
                  end
                  default: hs <= H_OFF;
                endcase
              end
            end

            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_fb_flush.sv
// Directed bench for ssd1306_fb_flush: an I2C API model with configurable
// done latency and post-done ready gap, a registered framebuffer model, and
// op-sequence comparison against hand-built expected frames.
module tb_ssd1306_fb_flush;

  localparam logic [7:0] F_IDLE  = 8'hFF;
  localparam logic [7:0] F_START = 8'h01;
  localparam logic [7:0] F_WR    = 8'h02;
  localparam logic [7:0] F_STOP  = 8'h03;

`ifdef SSD1306_INIT_EN
  localparam bit INIT_BUILD = 1'b1;
`else
  localparam bit INIT_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_req;
  logic       busy;
  logic       flush_done;
  logic       fb_rd;
  logic [9:0] fb_addr;
  logic [7:0] fb_rdata;
  logic       api_enable;
  logic [7:0] api_function;
  logic [6:0] api_slave_addr;
  logic [7:0] api_device_register;
  logic [7:0] api_data_tx;
  logic       api_ready;
  logic       api_done;

  ssd1306_fb_flush dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_req           (flush_req),
    .busy                (busy),
    .flush_done          (flush_done),
    .fb_rd               (fb_rd),
    .fb_addr             (fb_addr),
    .fb_rdata            (fb_rdata),
    .api_enable          (api_enable),
    .api_function        (api_function),
    .api_slave_addr      (api_slave_addr),
    .api_device_register (api_device_register),
    .api_data_tx         (api_data_tx),
    .api_ready           (api_ready),
    .api_done            (api_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int lat       = 1;
  int gap_extra = 0;
  int fb_mode   = 0;

  logic [15:0] ops[$];
  logic [15:0] exp_ops[$];
  int          done_idle[$];
  int          rd_count   = 0;
  int          addr_err   = 0;
  int          done_count = 0;
  int          idle_cycles = 0;
  logic [9:0]  last_addr  = 10'd0;

  logic [7:0] init_bytes [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                                  8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                                  8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB,
                                  8'h40, 8'hA4, 8'hA6, 8'hAF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // API model: accepts a non-idle code while ready, drops ready, raises done
  // after lat cycles, keeps ready low gap_extra more cycles, then re-arms.
  initial begin
    int phase;
    int cnt;
    int gcnt;
    logic [7:0] hold_fn;
    phase = 0; cnt = 0; gcnt = 0; hold_fn = F_IDLE;
    api_ready = 1'b1;
    api_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase = 0; api_ready = 1'b1; api_done = 1'b0;
      end else begin
        case (phase)
          0: if (api_function != F_IDLE) begin
               hold_fn = api_function;
               ops.push_back({api_function, (api_function == F_WR) ? api_data_tx : 8'h00});
               cnt = lat;
               phase = 1;
             end
          1: begin
               api_ready = 1'b0;
               chk("wait_hold", api_function, hold_fn);
               if (cnt <= 1) begin
                 api_done = 1'b1;
                 gcnt = gap_extra;
                 phase = 2;
               end else begin
                 cnt--;
               end
             end
          default: begin
               api_done = 1'b0;
               if (gcnt == 0) begin
                 api_ready = 1'b1;
                 phase = 0;
               end else begin
                 chk("gap_idle", api_function, F_IDLE);
                 gcnt--;
               end
             end
        endcase
      end
    end
  end

  // Framebuffer: registered read, data one cycle after the strobe.
  initial begin
    fb_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (fb_rd) fb_rdata = (fb_mode == 0) ? 8'hA5 : fb_addr[7:0];
    end
  end

  // Read order, done pulses and idle cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fb_rd) begin
          if (fb_addr != 10'(rd_count % 1024)) addr_err++;
          last_addr = fb_addr;
          rd_count++;
        end
        if (flush_done) begin
          done_idle.push_back(idle_cycles);
          done_count++;
        end
        if (!busy) idle_cycles++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic add_frame(input bit with_init, input int mode);
    if (with_init && INIT_BUILD) begin
      exp_ops.push_back({F_START, 8'h00});
      exp_ops.push_back({F_WR, 8'h00});
      for (int i = 0; i < 25; i++) exp_ops.push_back({F_WR, init_bytes[i]});
      exp_ops.push_back({F_STOP, 8'h00});
    end
    exp_ops.push_back({F_START, 8'h00});
    exp_ops.push_back({F_WR, 8'h00});
    exp_ops.push_back({F_WR, 8'h21});
    exp_ops.push_back({F_WR, 8'h00});
    exp_ops.push_back({F_WR, 8'h7F});
    exp_ops.push_back({F_WR, 8'h22});
    exp_ops.push_back({F_WR, 8'h00});
    exp_ops.push_back({F_WR, 8'h07});
    exp_ops.push_back({F_STOP, 8'h00});
    exp_ops.push_back({F_START, 8'h00});
    exp_ops.push_back({F_WR, 8'h40});
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      a = 10'(i);
      exp_ops.push_back({F_WR, (mode == 0) ? 8'hA5 : a[7:0]});
    end
    exp_ops.push_back({F_STOP, 8'h00});
  endtask

  task automatic compare_ops(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < exp_ops.size() && i < ops.size(); i++)
      if (ops[i] !== exp_ops[i]) nbad++;
    chk({tag, "_op_count"}, ops.size(), exp_ops.size());
    chk({tag, "_op_mismatches"}, nbad, 0);
  endtask

  task automatic clear_all();
    ops.delete();
    exp_ops.delete();
    done_idle.delete();
    rd_count = 0;
    addr_err = 0;
    done_count = 0;
    idle_cycles = 0;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int c = 0; c < 15000 && done_count < target; c++) @(negedge clk);
    chk(tag, done_count, target);
  endtask

  initial begin
    int d;
    reset = 1'b1;
    flush_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_fb_rd", fb_rd, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_api_function", api_function, F_IDLE);
    chk("rst_api_data_tx", api_data_tx, 0);
    chk("rst_api_enable", api_enable, 0);
    chk("slave_addr", api_slave_addr, 7'h3C);
    chk("device_register", api_device_register, 8'h00);

    reset = 1'b0;
    @(posedge clk); #1;
    chk("enable_after_reset", api_enable, 1);

    // Start latency, then abort by reset near byte 300
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk); #1;
    chk("start_latency", api_function, F_START);
    chk("busy_on_start", busy, 1);
    @(negedge clk);
    flush_req = 1'b0;
    for (int c = 0; c < 5000 && rd_count < 301; c++) @(negedge clk);
    chk("reached_byte300", (rd_count >= 301), 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_fn", api_function, F_IDLE);
    chk("abort_fb_rd", fb_rd, 0);
    chk("abort_fb_addr", fb_addr, 0);
    chk("abort_enable", api_enable, 0);
    chk("abort_data_tx", api_data_tx, 0);
    chk("abort_flush_done", flush_done, 0);
    repeat (2) @(negedge clk);
    clear_all();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full frame, all 0xA5, done 5 cycles after accept
    lat = 5;
    fb_mode = 0;
    add_frame(1'b1, 0);
    pulse_req();
    wait_done(1, "f_a5_done");
    repeat (50) @(negedge clk);
    chk("f_a5_done_once", done_count, 1);
    compare_ops("f_a5");
    chk("f_a5_reads", rd_count, 1024);
    chk("f_a5_addr_order", addr_err, 0);
    chk("f_a5_last_addr", last_addr, 10'd1023);

    // Incrementing pattern, no init on later flush
    clear_all();
    lat = 1;
    fb_mode = 1;
    add_frame(1'b0, 1);
    pulse_req();
    wait_done(1, "f_inc_done");
    repeat (50) @(negedge clk);
    compare_ops("f_inc");
    chk("f_inc_reads", rd_count, 1024);
    chk("f_inc_addr_order", addr_err, 0);
    chk("f_inc_last_addr", last_addr, 10'd1023);
    chk("f_inc_idle_busy", busy, 0);

    // Three requests during busy coalesce into one extra frame
    clear_all();
    add_frame(1'b0, 1);
    add_frame(1'b0, 1);
    pulse_req();
    repeat (100) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      repeat (200) @(negedge clk);
    end
    wait_done(1, "pend_done1");
    wait_done(2, "pend_done2");
    repeat (3000) @(negedge clk);
    chk("pend_frames", done_count, 2);
    compare_ops("pend");
    chk("pend_reads", rd_count, 2048);
    chk("pend_addr_order", addr_err, 0);
    d = (done_idle.size() >= 2) ? (done_idle[1] - done_idle[0]) : 0;
    chk("pend_idle_gap", (d >= 1 && d <= 2), 1);
    chk("pend_final_busy", busy, 0);

    // Slow ready after done, then a request coinciding with flush_done
    clear_all();
    fb_mode = 0;
    add_frame(1'b0, 0);
    add_frame(1'b0, 0);
    gap_extra = 20;
    pulse_req();
    for (int c = 0; c < 2000 && ops.size() < 10; c++) @(negedge clk);
    chk("slow_ops_seen", (ops.size() >= 10), 1);
    gap_extra = 0;
    for (int c = 0; c < 15000 && !flush_done; c++) @(negedge clk);
    chk("coll_saw_done", flush_done, 1);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    wait_done(2, "coll_done2");
    repeat (200) @(negedge clk);
    chk("coll_frames", done_count, 2);
    compare_ops("coll");
    chk("coll_addr_order", addr_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
